// File: rtl/arp_pkg.sv
// Shared ARP definitions for the transmit serializer and the field parser.
// Holds protocol constants, the FSM state type, the word-index type, the
// latched field bundle and the word-packing function both sides agree on.
package arp_pkg;

  localparam int unsigned ARP_WORDS = 7;

  localparam logic [15:0] ARP_HTYPE_ETH  = 16'h0001;
  localparam logic [15:0] ARP_PTYPE_IPV4 = 16'h0800;
  localparam logic [15:0] ARP_OP_REQ     = 16'h0001;
  localparam logic [15:0] ARP_OP_REPLY   = 16'h0002;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StSend = 2'd1,
    StGap  = 2'd2
  } arp_state_e;

  typedef logic [2:0] arp_idx_t;

  localparam arp_idx_t ARP_LAST_IDX = arp_idx_t'(ARP_WORDS - 1);

  typedef struct packed {
    logic [15:0] hdr_type;
    logic [15:0] proto_type;
    logic [7:0]  hdw_length;
    logic [7:0]  pro_length;
    logic [15:0] operation;
    logic [47:0] send_hdr_addr;
    logic [31:0] send_ip_addr;
    logic [47:0] target_hdr_addr;
    logic [31:0] target_ip_addr;
  } arp_fields_t;

  // Word idx of the packet; index 7 is never a real word and yields zero.
  function automatic logic [31:0] arp_pack_word(arp_idx_t idx, arp_fields_t f);
    logic [31:0] w;
    case (idx)
      3'd0:    w = {f.hdr_type, f.proto_type};
      3'd1:    w = {f.hdw_length, f.pro_length, f.operation};
      3'd2:    w = f.send_hdr_addr[47:16];
      3'd3:    w = {f.send_hdr_addr[15:0], f.send_ip_addr[31:16]};
      3'd4:    w = {f.send_ip_addr[15:0], f.target_hdr_addr[47:32]};
      3'd5:    w = f.target_hdr_addr[31:0];
      3'd6:    w = f.target_ip_addr;
      default: w = 32'h0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/arp_tx_if.sv
// 32-bit valid/ready word stream carrying ARP packets.
//   tx_data  : output word
//   tx_valid : tx_data is valid
//   tx_last  : marks the final word of a packet
//   tx_ready : sink accepts the word when tx_valid and tx_ready are high at an edge
interface arp_tx_if;

  logic [31:0] tx_data;
  logic        tx_valid;
  logic        tx_last;
  logic        tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    output tx_last,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    input  tx_last,
    output tx_ready
  );

endinterface

// File: rtl/arp_tx.sv
// ARP packet serializer. On an accepted start the header fields are latched
// and sent as seven 32-bit words, word 0 first, over the tx stream, followed
// by an idle gap of IFG_CYCLES cycles before the next start is accepted.
//   clk, rst         : clock, synchronous active-high reset
//   start            : send request, honoured only while tx_idle is high
//   hdr_type .. target_ip_addr : ARP header fields, sampled with start
//   tx_idle          : a start this cycle will be accepted
//   tx_done          : one-cycle pulse after the last word is accepted
//   tx               : word stream (master side)
module arp_tx
  import arp_pkg::*;
#(
  parameter int unsigned IFG_CYCLES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [15:0]  hdr_type,
  input  logic [15:0]  proto_type,
  input  logic [7:0]   hdw_length,
  input  logic [7:0]   pro_length,
  input  logic [15:0]  operation,
  input  logic [47:0]  send_hdr_addr,
  input  logic [31:0]  send_ip_addr,
  input  logic [47:0]  target_hdr_addr,
  input  logic [31:0]  target_ip_addr,
  output logic         tx_idle,
  output logic         tx_done,
  arp_tx_if.master     tx
);

  localparam logic [7:0] GapLast = 8'((IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0);

  arp_state_e  state_q, state_d;
  arp_idx_t    idx_q, idx_d;
  logic [7:0]  gap_q, gap_d;
  arp_fields_t fields_q, fields_d;
  logic [31:0] data_q, data_d;
  logic        valid_q, valid_d;
  logic        last_q, last_d;
  logic        done_q, done_d;
  logic        idle_q, idle_d;

  arp_fields_t in_fields;
  arp_idx_t    idx_next;

  assign in_fields = '{
    hdr_type:        hdr_type,
    proto_type:      proto_type,
    hdw_length:      hdw_length,
    pro_length:      pro_length,
    operation:       operation,
    send_hdr_addr:   send_hdr_addr,
    send_ip_addr:    send_ip_addr,
    target_hdr_addr: target_hdr_addr,
    target_ip_addr:  target_ip_addr
  };

  assign idx_next = idx_q + 3'd1;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    gap_d    = gap_q;
    fields_d = fields_q;
    data_d   = data_q;
    valid_d  = valid_q;
    last_d   = last_q;
    idle_d   = idle_q;
    done_d   = 1'b0;

    case (state_q)
      StIdle: begin
        if (start) begin
          fields_d = in_fields;
          state_d  = StSend;
          idx_d    = 3'd0;
          data_d   = arp_pack_word(3'd0, in_fields);
          valid_d  = 1'b1;
          last_d   = 1'b0;
          idle_d   = 1'b0;
        end
      end

      StSend: begin
        // Without tx_ready every output simply holds.
        if (tx.tx_ready) begin
          if (idx_q == ARP_LAST_IDX) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            done_d  = 1'b1;
            idx_d   = 3'd0;
            if (IFG_CYCLES > 0) begin
              state_d = StGap;
              gap_d   = 8'd0;
            end else begin
              state_d = StIdle;
              idle_d  = 1'b1;
            end
          end else begin
            idx_d  = idx_next;
            data_d = arp_pack_word(idx_next, fields_q);
            last_d = (idx_next == ARP_LAST_IDX);
          end
        end
      end

      StGap: begin
        if (gap_q == GapLast) begin
          state_d = StIdle;
          gap_d   = 8'd0;
          idle_d  = 1'b1;
        end else begin
          gap_d = gap_q + 8'd1;
        end
      end

      default: begin
        state_d = StIdle;
        idle_d  = 1'b1;
        valid_d = 1'b0;
        last_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      idx_q    <= 3'd0;
      gap_q    <= 8'd0;
      fields_q <= '0;
      data_q   <= 32'h0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      done_q   <= 1'b0;
      idle_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      gap_q    <= gap_d;
      fields_q <= fields_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
      done_q   <= done_d;
      idle_q   <= idle_d;
    end
  end

  assign tx.tx_data  = data_q;
  assign tx.tx_valid = valid_q;
  assign tx.tx_last  = last_q;
  assign tx_done     = done_q;
  assign tx_idle     = idle_q;

endmodule

// File: doc/arp_tx.md
Name: arp_tx

Overview:
- ARP packet serializer: latches a full set of ARP header fields on a start request and emits them as seven 32-bit words over a valid/ready stream, word 0 first.
- Transmit-side counterpart to the ARP field parser; the word packing is identical, so arp_tx output looped into the parser reproduces the fields.
- Sits between the ARP request/reply generation logic and the 32-bit MAC transmit datapath.

Parameters:
- IFG_CYCLES, 2, idle gap in clk cycles after the last word is accepted before a new start is accepted; legal range 0..255.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request to send; sampled only when tx_idle=1.
- hdr_type  in  16  hardware type.
- proto_type  in  16  protocol type.
- hdw_length  in  8  hardware address length.
- pro_length  in  8  protocol address length.
- operation  in  16  opcode (1 = request, 2 = reply).
- send_hdr_addr  in  48  sender MAC.
- send_ip_addr  in  32  sender IP.
- target_hdr_addr  in  48  target MAC.
- target_ip_addr  in  32  target IP.
- tx_idle  out  1  high when a start will be accepted this cycle.
- tx_data  out  32  output word.
- tx_valid  out  1  tx_data is valid.
- tx_last  out  1  high with word 6.
- tx_ready  in  1  downstream accepts the word when tx_valid and tx_ready are both high at a rising edge.
- tx_done  out  1  one-cycle pulse after word 6 is accepted.

Behaviour:
- Reset (synchronous, rst=1 at an edge): state=IDLE, tx_idle=1, tx_valid=0, tx_last=0, tx_done=0, tx_data=0, word index=0, gap counter=0, field latches=0. rst has priority over every other input, including mid-packet; a packet in flight is dropped without tx_done.
- Word packing (bit 31 is MSB):
  - W0 = {hdr_type, proto_type}
  - W1 = {hdw_length, pro_length, operation}
  - W2 = send_hdr_addr[47:16]
  - W3 = {send_hdr_addr[15:0], send_ip_addr[31:16]}
  - W4 = {send_ip_addr[15:0], target_hdr_addr[47:32]}
  - W5 = target_hdr_addr[31:0]
  - W6 = target_ip_addr
- All field inputs are captured into internal registers on the edge where start=1 and tx_idle=1. Field changes after that edge do not affect the packet.
- FSM states: IDLE, SEND, GAP.
  - IDLE: tx_idle=1. start=1 -> SEND, index=0. tx_valid=1 with W0 from the next cycle, giving 1-cycle latency start->first valid.
  - SEND: tx_valid=1, tx_data=W[index], tx_last=(index==6).
    - On an edge with tx_ready=1 and index<6: index increments and the next word is presented the following cycle, so back-to-back ready gives one word per cycle.
    - On an edge with tx_ready=1 and index==6: tx_valid=0, tx_last=0, tx_done=1 for the next cycle. Then -> GAP if IFG_CYCLES>0, else -> IDLE.
    - tx_ready=0: tx_data, tx_valid and tx_last hold unchanged (AXI-style; valid never drops without acceptance).
  - GAP: counter runs 0..IFG_CYCLES-1, then -> IDLE. tx_idle=0 throughout, so start is ignored.
- start while not idle is ignored, not queued.
- tx_done and tx_idle rise on the same cycle when IFG_CYCLES=0. A start in that cycle is accepted, allowing back-to-back packets with exactly one idle (non-valid) cycle between them.
- tx_data holds the last word value when tx_valid=0; it is don't-care for consumers.
- Registered outputs only; no combinational path from tx_ready to tx_valid or tx_data.

Decomposition:
- Shared package arp_pkg:
  - ARP_WORDS=7
  - ARP_HTYPE_ETH=16'h0001, ARP_PTYPE_IPV4=16'h0800, ARP_OP_REQ=16'h0001, ARP_OP_REPLY=16'h0002
  - state encodings IDLE/SEND/GAP
  - word-index type, 3 bits
- The packing is a small pure function (index plus latched fields -> 32-bit word) held in the package so the parser and transmitter share one definition.
- No sub-module needed; single module.

Test Plan:
- Request, tx_ready tied 1, IFG_CYCLES=2: start with htype 0001, ptype 0800, hlen 06, plen 04, op 0001, SHA 00:11:22:33:44:55, SPA C0A80001, THA 0, TPA C0A80002 -> valid from cycle+1 for 7 consecutive cycles carrying 00010800, 06040001, 00112233, 4455C0A8, 00010000, 00000000, C0A80002; tx_last only on the 7th; tx_done one cycle later; tx_idle returns 2 cycles after tx_done.
- Backpressure: same packet with tx_ready deasserted for 3 cycles on W3 -> 4455C0A8 held stable with valid=1 for 4 cycles; remaining order intact; word count=7.
- Field change/start during busy: alter all inputs and pulse start during SEND and GAP -> packet content unchanged; no second packet emitted.
- Reset mid-packet: rst=1 while presenting W4 -> next cycle tx_valid=0, tx_idle=1, no tx_done; a new start then sends W0 first.
- IFG_CYCLES=0 back-to-back: start held high continuously -> packets separated by exactly one non-valid cycle; each tx_done pulse is 1 cycle wide.
- Loopback: arp_tx feeding the ARP parser, opcode 0002 reply -> every parser field output equals the corresponding arp_tx input.
